// File: rtl/waveform_sweep_sequencer.sv
// waveform_sweep_sequencer
// Drives the sawtooth generator's frequency bus. When idle it forwards the
// manual frequency from the parameter FSM; on a start request it runs an
// automated sweep (single up, single down, continuous triangle or repeating
// up-ramp), holding each frequency for dwellCycles enabled clock cycles.
//
// Ports
//   clk, reset      clock, asynchronous active-low reset
//   enable          sweep advance enable (low pauses the dwell count)
//   start, abort    sweep request (IDLE only) / terminate sweep (any state)
//   mode            00 up, 01 down, 10 triangle, 11 repeating up-ramp
//   startFreq/stopFreq/stepFreq/dwellCycles  sweep configuration
//   manualFreq, manualAmp   pass-through settings from the parameter FSM
//   frequency, amplitude    to the generator
//   busy, stepTick, sweepDone, configError  status
module waveform_sweep_sequencer #(
  parameter int FREQ_W  = 23,
  parameter int AMP_W   = 8,
  parameter int DWELL_W = 24
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               start,
  input  logic               abort,
  input  logic [1:0]         mode,
  input  logic [FREQ_W-1:0]  startFreq,
  input  logic [FREQ_W-1:0]  stopFreq,
  input  logic [FREQ_W-1:0]  stepFreq,
  input  logic [DWELL_W-1:0] dwellCycles,
  input  logic [FREQ_W-1:0]  manualFreq,
  input  logic [AMP_W-1:0]   manualAmp,
  output logic [FREQ_W-1:0]  frequency,
  output logic [AMP_W-1:0]   amplitude,
  output logic               busy,
  output logic               stepTick,
  output logic               sweepDone,
  output logic               configError
);
  typedef enum logic [1:0] {S_IDLE, S_DWELL, S_STEP, S_DONE} state_e;

  localparam logic [1:0]         M_DOWN = 2'b01;
  localparam logic [1:0]         M_TRI  = 2'b10;
  localparam logic [1:0]         M_RAMP = 2'b11;
  localparam logic [DWELL_W-1:0] ONE    = DWELL_W'(1);

  state_e               state_q, state_d;
  logic [1:0]           mode_q, mode_d;
  logic [FREQ_W-1:0]    lo_q, lo_d, hi_q, hi_d, step_q, step_d, freq_q, freq_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d, cnt_q, cnt_d;
  logic                 up_q, up_d, tick_q, tick_d, cerr_q, cerr_d;
  logic [AMP_W-1:0]     amp_q;

  // Next-value datapath; one extra bit so cur+step and start+step never wrap.
  logic [FREQ_W:0]      up_sum, lo_plus;
  logic [FREQ_W-1:0]    nxt;
  logic                 nxt_up, finish;
  logic [DWELL_W-1:0]   d_in;
  logic                 cfg_bad;

  always_comb begin
    up_sum  = {1'b0, freq_q} + {1'b0, step_q};
    lo_plus = {1'b0, lo_q}   + {1'b0, step_q};
    nxt     = freq_q;
    nxt_up  = up_q;
    finish  = 1'b0;
    if (up_q) begin
      if (freq_q == hi_q) begin
        case (mode_q)
          // stop-step below start collapses to start (no underflow taken)
          M_TRI:   begin
            nxt_up = 1'b0;
            nxt    = ({1'b0, hi_q} < lo_plus) ? lo_q : hi_q - step_q;
          end
          M_RAMP:  nxt = lo_q;
          default: finish = 1'b1;
        endcase
      end else begin
        nxt = (up_sum >= {1'b0, hi_q}) ? hi_q : up_sum[FREQ_W-1:0];
      end
    end else begin
      if (freq_q == lo_q) begin
        if (mode_q == M_TRI) begin
          nxt_up = 1'b1;
          nxt    = (lo_plus > {1'b0, hi_q}) ? hi_q : lo_plus[FREQ_W-1:0];
        end else begin
          finish = 1'b1;
        end
      end else begin
        nxt = ({1'b0, freq_q} < lo_plus) ? lo_q : freq_q - step_q;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    step_d  = step_q;
    dwell_d = dwell_q;
    up_d    = up_q;
    freq_d  = freq_q;
    cnt_d   = cnt_q;
    tick_d  = 1'b0;
    cerr_d  = 1'b0;
    d_in    = (dwellCycles == '0) ? ONE : dwellCycles;
    cfg_bad = (startFreq >= stopFreq) || (stepFreq == '0);
    case (state_q)
      S_IDLE: begin
        freq_d = manualFreq;
        if (start && !abort) begin
          if (cfg_bad) begin
            cerr_d = 1'b1;
          end else begin
            mode_d  = mode;
            lo_d    = startFreq;
            hi_d    = stopFreq;
            step_d  = stepFreq;
            dwell_d = d_in;
            up_d    = (mode != M_DOWN);
            freq_d  = (mode == M_DOWN) ? stopFreq : startFreq;
            cnt_d   = d_in - ONE;
            // STEP is the last hold cycle, so a 1-cycle dwell skips DWELL.
            state_d = (d_in == ONE) ? S_STEP : S_DWELL;
          end
        end
      end
      S_DWELL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (enable) begin
          if (cnt_q <= ONE) begin
            cnt_d   = '0;
            state_d = S_STEP;
          end else begin
            cnt_d = cnt_q - ONE;
          end
        end
      end
      S_STEP: begin
        if (abort) begin
          state_d = S_IDLE;
        end else if (enable) begin
          if (finish) begin
            state_d = S_DONE;
          end else begin
            freq_d  = nxt;
            up_d    = nxt_up;
            tick_d  = 1'b1;
            cnt_d   = dwell_q - ONE;
            state_d = (dwell_q == ONE) ? S_STEP : S_DWELL;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      mode_q  <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      step_q  <= '0;
      dwell_q <= '0;
      up_q    <= 1'b0;
      freq_q  <= '0;
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      cerr_q  <= 1'b0;
      amp_q   <= '0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      step_q  <= step_d;
      dwell_q <= dwell_d;
      up_q    <= up_d;
      freq_q  <= freq_d;
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      cerr_q  <= cerr_d;
      amp_q   <= manualAmp;
    end
  end

  assign frequency   = freq_q;
  assign amplitude   = amp_q;
  assign busy        = (state_q == S_DWELL) || (state_q == S_STEP);
  assign sweepDone   = (state_q == S_DONE);
  assign stepTick    = tick_q;
  assign configError = cerr_q;
endmodule

// File: tb/tb_waveform_sweep_sequencer.sv
// Randomized bench for waveform_sweep_sequencer. Expected frequencies come
// from a sweep value list built from the sweep rules (ramp lists, reversed
// for down, concatenated for triangle/repeat); the current value is the
// list entry at (enabled cycles elapsed / dwell).
module tb_waveform_sweep_sequencer;
  localparam int FREQ_W = 23, AMP_W = 8, DWELL_W = 24;

  logic               clk = 1'b0, reset = 1'b0, enable = 1'b0, start = 1'b0, abort = 1'b0;
  logic [1:0]         mode = '0;
  logic [FREQ_W-1:0]  startFreq = '0, stopFreq = '0, stepFreq = '0, manualFreq = '0;
  logic [DWELL_W-1:0] dwellCycles = '0;
  logic [AMP_W-1:0]   manualAmp = '0;
  logic [FREQ_W-1:0]  frequency;
  logic [AMP_W-1:0]   amplitude;
  logic               busy, stepTick, sweepDone, configError;

  int n_chk = 0, n_err = 0;
  logic [AMP_W-1:0]  amp_edge;
  logic [FREQ_W-1:0] man_edge;

  always #5 clk = ~clk;

  waveform_sweep_sequencer #(.FREQ_W(FREQ_W), .AMP_W(AMP_W), .DWELL_W(DWELL_W)) u_dut (
    .clk(clk), .reset(reset), .enable(enable), .start(start), .abort(abort),
    .mode(mode), .startFreq(startFreq), .stopFreq(stopFreq), .stepFreq(stepFreq),
    .dwellCycles(dwellCycles), .manualFreq(manualFreq), .manualAmp(manualAmp),
    .frequency(frequency), .amplitude(amplitude), .busy(busy), .stepTick(stepTick),
    .sweepDone(sweepDone), .configError(configError)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Inputs are driven at negedge; remember what the next posedge samples.
  task automatic cycle();
    amp_edge = manualAmp;
    man_edge = manualFreq;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, ".freq"}, 32'(frequency), 32'(man_edge));
    chk({tag, ".busy"}, 32'(busy), 0);
    chk({tag, ".tick"}, 32'(stepTick), 0);
    chk({tag, ".done"}, 32'(sweepDone), 0);
    chk({tag, ".amp"},  32'(amplitude), 32'(amp_edge));
  endtask

  // en_mode: 0 always enabled, 1 random, 2 six-cycle pause at cycles 5..10
  task automatic run_sweep(input int md, input int st, input int sp, input int stp,
                           input int dw, input int abort_at, input int en_mode);
    int up[$], dn[$], sq[$];
    int v, d, n, k, ph, need, ef;
    bit single, en, ab, et, eb, ed;
    d = (dw == 0) ? 1 : dw;
    v = st; while (v < sp) begin up.push_back(v); v += stp; end
    up.push_back(sp);
    v = sp; while (v > st) begin dn.push_back(v); v -= stp; end
    dn.push_back(st);
    need = 3000 / d + 4;
    single = (md < 2);
    if (md == 0) sq = up;
    else if (md == 1) sq = dn;
    else if (md == 2) begin
      sq = up;
      while (sq.size() < need) begin
        for (int i = 1; i < dn.size(); i++) sq.push_back(dn[i]);
        for (int i = 1; i < up.size(); i++) sq.push_back(up[i]);
      end
    end else begin
      while (sq.size() < need) foreach (up[i]) sq.push_back(up[i]);
    end
    n = sq.size();

    mode = 2'(md); startFreq = FREQ_W'(st); stopFreq = FREQ_W'(sp);
    stepFreq = FREQ_W'(stp); dwellCycles = DWELL_W'(dw);
    start = 1'b1; abort = 1'b0; enable = 1'b1;
    manualFreq = FREQ_W'($urandom); manualAmp = AMP_W'($urandom);
    cycle();
    start = 1'b0;
    // ph: 1 running, 2 done pulse, 3 back in idle (freq not yet reloaded), 4 finished
    ph = 1; k = 0; ef = sq[0]; eb = 1'b1; et = 1'b0; ed = 1'b0;
    for (int j = 0; j < 3000 && ph != 4; j++) begin
      chk("sw.freq", 32'(frequency), 32'(ef));
      chk("sw.busy", 32'(busy), 32'(eb));
      chk("sw.tick", 32'(stepTick), 32'(et));
      chk("sw.done", 32'(sweepDone), 32'(ed));
      chk("sw.cerr", 32'(configError), 0);
      chk("sw.amp",  32'(amplitude), 32'(amp_edge));
      if (ph == 3) begin
        cycle();
        check_idle("sw.end");
        ph = 4;
      end else begin
        case (en_mode)
          0:       en = 1'b1;
          1:       en = ($urandom_range(0, 3) != 0);
          default: en = !(j >= 5 && j < 11);
        endcase
        ab = (j == abort_at);
        enable = en; abort = ab;
        start = ($urandom_range(0, 7) == 0);   // ignored outside IDLE
        startFreq = FREQ_W'($urandom); stopFreq = FREQ_W'($urandom);
        stepFreq = FREQ_W'($urandom); dwellCycles = DWELL_W'($urandom_range(0, 9));
        mode = 2'($urandom); manualFreq = FREQ_W'($urandom); manualAmp = AMP_W'($urandom);
        cycle();
        start = 1'b0; abort = 1'b0;
        if (ph == 1) begin
          et = 1'b0;
          if (ab) begin
            ph = 3; eb = 1'b0;
          end else if (en) begin
            k++;
            if (single && k == n * d) begin
              ph = 2; eb = 1'b0; ed = 1'b1;
            end else begin
              et = (k % d == 0);
              ef = sq[k / d];
            end
          end
        end else begin
          ph = 3; ed = 1'b0;
        end
      end
    end
    chk("sw.timeout", 32'(ph), 4);
  endtask

  initial begin
    int md, st, sp, ab;
    #1;
    chk("rst.freq", 32'(frequency), 0);
    chk("rst.amp",  32'(amplitude), 0);
    chk("rst.busy", 32'(busy), 0);
    chk("rst.tick", 32'(stepTick), 0);
    chk("rst.done", 32'(sweepDone), 0);
    chk("rst.cerr", 32'(configError), 0);
    @(negedge clk);
    reset = 1'b1;
    manualFreq = 23'd1234; manualAmp = 8'hA5;
    cycle();
    check_idle("idle");

    run_sweep(0, 100, 130, 10, 3, -1, 0);
    run_sweep(1, 0, 25, 10, 1, -1, 0);
    run_sweep(2, 0, 20, 10, 2, 12, 0);
    run_sweep(3, 5, 7, 1, 4, 40, 2);
    run_sweep(0, 8388600, 8388607, 5, 2, -1, 0);
    run_sweep(2, 8388590, 8388607, 20, 1, 15, 1);
    run_sweep(1, 3, 200, 7, 0, -1, 1);

    // rejected configurations
    startFreq = 23'd50; stopFreq = 23'd50; stepFreq = 23'd5; dwellCycles = 24'd2;
    mode = 2'b00; start = 1'b1; enable = 1'b1;
    cycle(); start = 1'b0;
    chk("cerr.eq.pulse", 32'(configError), 1);
    chk("cerr.eq.busy", 32'(busy), 0);
    cycle();
    chk("cerr.eq.clear", 32'(configError), 0);
    check_idle("cerr.eq");
    startFreq = 23'd10; stopFreq = 23'd60; stepFreq = 23'd0; start = 1'b1;
    cycle(); start = 1'b0;
    chk("cerr.step0.pulse", 32'(configError), 1);
    chk("cerr.step0.busy", 32'(busy), 0);
    cycle();
    chk("cerr.step0.clear", 32'(configError), 0);

    // asynchronous reset mid-sweep
    startFreq = 23'd100; stopFreq = 23'd200; stepFreq = 23'd10; dwellCycles = 24'd3;
    start = 1'b1; manualAmp = 8'h3C;
    cycle(); start = 1'b0;
    cycle(); cycle();
    chk("pre_rst.busy", 32'(busy), 1);
    #2 reset = 1'b0;
    #1;
    chk("arst.freq", 32'(frequency), 0);
    chk("arst.amp",  32'(amplitude), 0);
    chk("arst.busy", 32'(busy), 0);
    chk("arst.tick", 32'(stepTick), 0);
    chk("arst.done", 32'(sweepDone), 0);
    @(negedge clk);
    reset = 1'b1;
    start = 1'b1; abort = 1'b1; manualFreq = 23'd777; manualAmp = 8'hA5;
    cycle(); start = 1'b0; abort = 1'b0;
    check_idle("abort_wins");
    chk("amp.a5", 32'(amplitude), 32'h A5);
    cycle();
    check_idle("abort_wins2");

    for (int i = 0; i < 25; i++) begin
      md = $urandom_range(0, 3);
      st = $urandom_range(0, 300);
      sp = st + $urandom_range(1, 80);
      ab = (md < 2) ? (($urandom_range(0, 3) == 0) ? $urandom_range(0, 20) : -1)
                    : $urandom_range(5, 60);
      run_sweep(md, st, sp, $urandom_range(1, 30), $urandom_range(0, 4), ab,
                $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
